mac_lane_accum: RTL and testbench

MAC_LANE_ACCUM -- requirements
Module: mac_lane_accum

---
 rtl/mac_lane_accum.sv | 163 ++++++++++++++++
 tb/tb_mac_lane_accum.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_lane_accum.sv
// Multi-lane multiply-accumulate engine: unsigned features times signed weights,
// accumulated per job with saturation, followed by a bias add, optional ReLU and a result handshake.
`timescale 1ns/1ps
module mac_lane_accum #(
  parameter int LANES  = 4,
  parameter int DW     = 8,
  parameter int BIAS_W = 9,
  parameter int ACC_W  = 26,
  parameter int LEN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  input  logic [BIAS_W-1:0]     bias,
  input  logic                  relu_en,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*DW-1:0]   input_feature,
  input  logic [LANES*DW-1:0]   weight,
  input  logic [LANES-1:0]      lane_en,
  output logic [ACC_W-1:0]      result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sat,
  output logic                  busy
);

  localparam int PW = 2*DW + 1;
  // One guard bit beyond the lane-count growth keeps the beat sum wider than a single product.
  localparam int SW = PW + $clog2(LANES) + 1;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_BIAS,
    S_OUT
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [LEN_W-1:0]   r_rem;
  logic [BIAS_W-1:0]  r_bias;
  logic               r_relu;
  logic               r_s1_v;
  logic [SW-1:0]      r_s1_sum;
  logic [ACC_W-1:0]   r_acc;
  logic               r_sat;
  logic [ACC_W-1:0]   r_result;

  logic [PW-1:0]      w_feat_ext [LANES];
  logic [PW-1:0]      w_wt_ext   [LANES];
  logic [PW-1:0]      w_prod     [LANES];
  logic [SW-1:0]      w_beat_sum;
  logic               w_accept;

  logic [ACC_W:0]     w_acc_ext;
  logic               w_acc_ovf;
  logic [ACC_W-1:0]   w_acc_next;
  logic [ACC_W:0]     w_bias_ext;
  logic               w_bias_ovf;
  logic [ACC_W-1:0]   w_bias_sat;
  logic [ACC_W-1:0]   w_final;

  assign in_ready  = (r_state == S_RUN) && (r_rem != '0) && !flush;
  assign w_accept  = in_valid && in_ready;
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_OUT);
  assign result    = r_result;
  assign sat       = r_sat;

  // Zero-extend features, sign-extend weights; the low PW bits of the product are the signed result.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_beat_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      w_feat_ext[i] = {{(PW-DW){1'b0}}, input_feature[i*DW +: DW]};
      w_wt_ext[i]   = {{(PW-DW){weight[i*DW+DW-1]}}, weight[i*DW +: DW]};
      w_prod[i]     = lane_en[i] ? (w_feat_ext[i] * w_wt_ext[i]) : '0;
      w_beat_sum    = w_beat_sum + {{(SW-PW){w_prod[i][PW-1]}}, w_prod[i]};
    end
  end

  // Overflow is detected by the extra sign bit disagreeing with the result sign.
  always_comb begin
    w_acc_ext  = {r_acc[ACC_W-1], r_acc} + {{(ACC_W+1-SW){r_s1_sum[SW-1]}}, r_s1_sum};
    w_acc_ovf  = (w_acc_ext[ACC_W] != w_acc_ext[ACC_W-1]);
    w_acc_next = w_acc_ovf ? (w_acc_ext[ACC_W] ? ACC_MIN : ACC_MAX) : w_acc_ext[ACC_W-1:0];

    w_bias_ext = {r_acc[ACC_W-1], r_acc} + {{(ACC_W+1-BIAS_W){r_bias[BIAS_W-1]}}, r_bias};
    w_bias_ovf = (w_bias_ext[ACC_W] != w_bias_ext[ACC_W-1]);
    w_bias_sat = w_bias_ovf ? (w_bias_ext[ACC_W] ? ACC_MIN : ACC_MAX) : w_bias_ext[ACC_W-1:0];
    w_final    = (r_relu && w_bias_sat[ACC_W-1]) ? '0 : w_bias_sat;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start)        w_next = S_RUN;
      S_RUN:   if (r_rem == '0)  w_next = S_DRAIN;
      S_DRAIN: if (!r_s1_v)      w_next = S_BIAS;
      S_BIAS:                    w_next = S_OUT;
      S_OUT:   if (out_ready)    w_next = S_IDLE;
      default:                   w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rem    <= '0;
      r_bias   <= '0;
      r_relu   <= 1'b0;
      r_s1_v   <= 1'b0;
      r_s1_sum <= '0;
      r_acc    <= '0;
      r_sat    <= 1'b0;
      r_result <= '0;
    end else if (flush) begin
      r_rem  <= '0;
      r_s1_v <= 1'b0;
      r_acc  <= '0;
      r_sat  <= 1'b0;
    end else begin
      r_s1_v <= w_accept;
      if (w_accept) begin
        r_s1_sum <= w_beat_sum;
        r_rem    <= r_rem - 1'b1;
      end

      if (r_s1_v) begin
        r_acc <= w_acc_next;
        if (w_acc_ovf) r_sat <= 1'b1;
      end

      if (r_state == S_BIAS) begin
        r_result <= w_final;
        if (w_bias_ovf) r_sat <= 1'b1;
      end

      if ((r_state == S_IDLE) && start) begin
        r_rem  <= len;
        r_bias <= bias;
        r_relu <= relu_en;
        r_acc  <= '0;
        r_sat  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_lane_accum.sv
// Scoreboard bench for mac_lane_accum: directed jobs push expected results,
// a negedge monitor pops and compares on each output handshake.
`timescale 1ns/1ps
module tb_mac_lane_accum;

  localparam int LANES  = 4;
  localparam int DW     = 8;
  localparam int BIAS_W = 9;
  localparam int ACC_W  = 26;
  localparam int LEN_W  = 10;

  logic                clk;
  logic                rstn;
  logic                start;
  logic [LEN_W-1:0]    len;
  logic [BIAS_W-1:0]   bias;
  logic                relu_en;
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [LANES*DW-1:0] input_feature;
  logic [LANES*DW-1:0] weight;
  logic [LANES-1:0]    lane_en;
  logic [ACC_W-1:0]    result;
  logic                out_valid;
  logic                out_ready;
  logic                sat;
  logic                busy;

  mac_lane_accum #(
    .LANES(LANES), .DW(DW), .BIAS_W(BIAS_W), .ACC_W(ACC_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .len(len), .bias(bias),
    .relu_en(relu_en), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .input_feature(input_feature), .weight(weight), .lane_en(lane_en),
    .result(result), .out_valid(out_valid), .out_ready(out_ready),
    .sat(sat), .busy(busy)
  );

  typedef struct {
    int res;
    bit sat;
    int rise;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int res_s(input logic [ACC_W-1:0] r);
    return int'($signed(r));
  endfunction

  // Monitor: records the edge on which out_valid rose and scores each handshake.
  initial begin
    bit   prev_ov;
    int   rise_cyc;
    exp_t e;
    prev_ov  = 1'b0;
    rise_cyc = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_ov = 1'b0;
      end else begin
        if (out_valid && !prev_ov) rise_cyc = cyc;
        prev_ov = out_valid;
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            check("unexpected_output", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("result", res_s(result), e.res);
            check("sat", sat, e.sat);
            check("out_valid_latency", rise_cyc, e.rise);
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge (or after the budget).
  task automatic send_beat(input logic [31:0] f, input logic [31:0] w, input logic [3:0] m,
                           output bit ok, output int edge_no);
    in_valid      = 1'b1;
    input_feature = f;
    weight        = w;
    lane_en       = m;
    ok            = 1'b0;
    edge_no       = cyc;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (ok) begin
      @(posedge clk);
      #1;
      edge_no = cyc;
    end
  endtask

  task automatic run_job(input int n, input int b, input bit relu,
                         input logic [31:0] f, input logic [31:0] w, input logic [3:0] m,
                         input int exp_res, input bit exp_sat);
    int  acc_n;
    int  last;
    int  e_no;
    bit  ok;
    logic [31:0] nv;
    logic [31:0] bv;
    nv      = n;
    bv      = b;
    acc_n   = 0;
    start   = 1'b1;
    len     = nv[LEN_W-1:0];
    bias    = bv[BIAS_W-1:0];
    relu_en = relu;
    @(posedge clk);
    #1;
    start = 1'b0;
    last  = cyc;
    for (int i = 0; i < n; i++) begin
      send_beat(f, w, m, ok, e_no);
      if (ok) begin
        acc_n++;
        last = e_no;
      end
    end
    in_valid = 1'b0;
    check("beats_accepted", acc_n, n);
    sb_q.push_back('{exp_res, exp_sat, last + 3});
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("job_completes", busy, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit ok;
    int e_no;
    int seen;
    rstn          = 1'b0;
    start         = 1'b0;
    len           = '0;
    bias          = '0;
    relu_en       = 1'b0;
    flush         = 1'b0;
    in_valid      = 1'b0;
    input_feature = '0;
    weight        = '0;
    lane_en       = '0;
    out_ready     = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", res_s(result), 0);
    check("rst_sat", sat, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Basic dot product: 2 beats of 4*(1*2) plus bias 5.
    run_job(2, 5, 1'b0, {4{8'd1}}, {4{8'd2}}, 4'hF, 21, 1'b0);
    wait_idle();

    // ReLU off/on: only lane 0 enabled, 10*-3 + 4.
    run_job(1, 4, 1'b0, {8'd7, 8'd7, 8'd7, 8'd10}, {8'd9, 8'd9, 8'd9, 8'hFD}, 4'b0001, -26, 1'b0);
    wait_idle();
    run_job(1, 4, 1'b1, {8'd7, 8'd7, 8'd7, 8'd10}, {8'd9, 8'd9, 8'd9, 8'hFD}, 4'b0001, 0, 1'b0);
    wait_idle();

    // Negative saturation: 300 * 4 * (255 * -128) far below -2^25.
    run_job(300, 0, 1'b0, {4{8'd255}}, {4{8'h80}}, 4'hF, -33554432, 1'b1);
    wait_idle();

    // Flush after the first of three beats; a beat offered during flush must not be taken.
    start = 1'b1;
    len   = 10'd3;
    bias  = '0;
    @(posedge clk);
    #1;
    start = 1'b0;
    send_beat({4{8'd1}}, {4{8'd1}}, 4'hF, ok, e_no);
    check("flush_first_beat", ok, 1);
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_busy", busy, 0);
    check("flush_in_ready_after", in_ready, 0);
    check("flush_sat", sat, 0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("flush_no_output", seen, 0);
    @(posedge clk);
    #1;
    run_job(1, 0, 1'b0, {4{8'd1}}, {4{8'd1}}, 4'hF, 4, 1'b0);
    wait_idle();

    // Backpressure: 4*(2*3) - 1, held with start asserted throughout.
    out_ready = 1'b0;
    run_job(1, -1, 1'b0, {4{8'd2}}, {4{8'd3}}, 4'hF, 23, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("bp_out_valid", out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      start = 1'b1;
      len   = 10'd1;
      @(negedge clk);
      check("bp_result_hold", res_s(result), 23);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid_hold", out_valid, 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("bp_idle_after", busy, 0);
    check("bp_out_valid_fall", out_valid, 0);

    // Asynchronous reset in the middle of RUN.
    @(posedge clk);
    #1;
    start = 1'b1;
    len   = 10'd3;
    bias  = '0;
    @(posedge clk);
    #1;
    start = 1'b0;
    send_beat({4{8'd1}}, {4{8'd1}}, 4'hF, ok, e_no);
    rstn = 1'b0;
    #1;
    in_valid = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_result", res_s(result), 0);
    check("mid_rst_sat", sat, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    run_job(0, -7, 1'b0, {4{8'd1}}, {4{8'd1}}, 4'hF, -7, 1'b0);
    wait_idle();

    repeat (2) @(posedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
